// File: rtl/pid_cfg_writer.sv
// pid_cfg_writer: gathers fixed-length host word frames into single-cycle config writes
// (addr, chan, data LS-word first), with stall back-pressure, abort and idle timeout.
`default_nettype none

module pid_cfg_writer #(
  parameter int W_HOST    = 16,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter int TIMEOUT   = 1024,
  parameter int W_TO      = 11
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 host_dv,
  input  logic [W_HOST-1:0]    host_word,
  output logic                 host_rdy,
  input  logic                 host_abort,
  input  logic                 wr_stall,
  input  logic                 err_clr,
  output logic                 err_timeout,
  output logic [15:0]          wr_count,
  output logic                 wr_en,
  output logic [W_WR_ADDR-1:0] wr_addr,
  output logic [W_WR_CHAN-1:0] wr_chan,
  output logic [W_WR_DATA-1:0] wr_data
);

  localparam int N_DW    = (W_WR_DATA + W_HOST - 1) / W_HOST;
  localparam int N_WORDS = N_DW + 2;
  localparam int W_IDX   = $clog2(N_WORDS);
  localparam int W_SH    = N_DW * W_HOST;
  localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(N_WORDS - 1);
  localparam logic [W_TO-1:0]  TO_LAST  = W_TO'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W_IDX-1:0]     idx_q, idx_d;
  logic [W_TO-1:0]      timer_q, timer_d;
  logic [W_WR_ADDR-1:0] addr_sh_q, addr_sh_d;
  logic [W_WR_CHAN-1:0] chan_sh_q, chan_sh_d;
  logic [W_SH-1:0]      data_sh_q, data_sh_d;
  logic [W_WR_ADDR-1:0] addr_q, addr_d;
  logic [W_WR_CHAN-1:0] chan_q, chan_d;
  logic [W_WR_DATA-1:0] data_q, data_d;
  logic                 wr_en_q, wr_en_d;
  logic [15:0]          count_q, count_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 timeout_fire;

  assign host_rdy = (state_q != S_COMMIT);
  // Abort takes priority over a word offered in the same cycle.
  assign accept   = host_dv & host_rdy & ~host_abort;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = '0;
    addr_sh_d    = addr_sh_q;
    chan_sh_d    = chan_sh_q;
    data_sh_d    = data_sh_q;
    addr_d       = addr_q;
    chan_d       = chan_q;
    data_d       = data_q;
    wr_en_d      = 1'b0;
    count_d      = count_q;
    timeout_fire = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_sh_d = host_word[W_WR_ADDR-1:0];
          idx_d     = W_IDX'(1);
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        if (host_abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (idx_q == W_IDX'(1)) chan_sh_d = host_word[W_WR_CHAN-1:0];
          for (int i = 0; i < N_DW; i++) begin
            if (idx_q == W_IDX'(i + 2)) data_sh_d[i*W_HOST +: W_HOST] = host_word;
          end
          if (idx_q == LAST_IDX) state_d = S_COMMIT;
          else                   idx_d   = idx_q + W_IDX'(1);
        end else if (timer_q == TO_LAST) begin
          timeout_fire = 1'b1;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer_q + W_TO'(1);
        end
      end
      S_COMMIT: begin
        if (host_abort) begin
          state_d = S_IDLE;
        end else if (!wr_stall) begin
          addr_d  = addr_sh_q;
          chan_d  = chan_sh_q;
          data_d  = data_sh_q[W_WR_DATA-1:0];
          wr_en_d = 1'b1;
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (timeout_fire) err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      addr_sh_q <= '0;
      chan_sh_q <= '0;
      data_sh_q <= '0;
      addr_q    <= '0;
      chan_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      addr_sh_q <= addr_sh_d;
      chan_sh_q <= chan_sh_d;
      data_sh_q <= data_sh_d;
      addr_q    <= addr_d;
      chan_q    <= chan_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = addr_q;
  assign wr_chan     = chan_q;
  assign wr_data     = data_q;
  assign wr_count    = count_q;
  assign err_timeout = err_q;

endmodule

`default_nettype wire
